// File: rtl/moore_seq_gen_pkg.sv
// Shared definitions for the serial pattern transmitter: state encoding and
// the registered output bundle.
package moore_seq_gen_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic x;
      logic valid;
      logic frame;
      logic busy;
      logic done;
   } out_t;

endpackage

// File: rtl/moore_seq_gen_down_cnt.sv
// Loadable down-counter with zero flag; saturates at zero, load has priority.
module seq_down_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         zero
);

   // NOTE: synchronous reset -- rst is only looked at on the clock edge, so it
   // stays out of the sensitivity list.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/moore_seq_gen.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first,
// repeating it with optional idle gaps; all outputs registered.
module moore_seq_gen
   import moore_seq_gen_pkg::*;
#(
   parameter int   PAT_W    = 4,
   parameter int   CNT_W    = 4,
   parameter int   GAP_W    = 3,
   parameter logic IDLE_LVL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [PAT_W-1:0] pat,
   input  logic [CNT_W-1:0] reps,
   input  logic [GAP_W-1:0] gap,
   input  logic             stop,
   output logic             x,
   output logic             valid,
   output logic             frame,
   output logic             busy,
   output logic             done
);

   localparam int BIT_W = $clog2(PAT_W);

   state_t             state, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d, sr_q, sr_d;
   logic [BIT_W-1:0]   bit_cnt, bit_cnt_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               stop_q, stop_d;
   out_t               out_q, out_d;

   logic               rep_load, rep_dec, rep_zero;
   logic [CNT_W-1:0]   rep_val, rep_cnt;
   logic               gap_load, gap_dec, gap_zero;
   logic [GAP_W-1:0]   gap_val, gap_cnt;

   logic               last_bit, stop_seen;

   assign last_bit  = (bit_cnt == BIT_W'(PAT_W - 1));
   assign stop_seen = stop_q | stop;

   // rep_cnt holds repeats remaining after the current one
   seq_down_cnt #(.W(CNT_W)) u_rep_cnt (
      .clk(clk), .rst(rst), .load(rep_load), .load_val(rep_val),
      .dec(rep_dec), .cnt(rep_cnt), .zero(rep_zero)
   );

   // gap_cnt holds gap cycles remaining after the current one
   seq_down_cnt #(.W(GAP_W)) u_gap_cnt (
      .clk(clk), .rst(rst), .load(gap_load), .load_val(gap_val),
      .dec(gap_dec), .cnt(gap_cnt), .zero(gap_zero)
   );

   // NOTE: non-blocking assignments for every register so all flops update
   // together from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         pat_q   <= '0;
         sr_q    <= '0;
         bit_cnt <= '0;
         gap_q   <= '0;
         stop_q  <= 1'b0;
         out_q   <= '{x: IDLE_LVL, default: 1'b0};
      end else begin
         state   <= state_d;
         pat_q   <= pat_d;
         sr_q    <= sr_d;
         bit_cnt <= bit_cnt_d;
         gap_q   <= gap_d;
         stop_q  <= stop_d;
         out_q   <= out_d;
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state;
      pat_d     = pat_q;
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt;
      gap_d     = gap_q;
      stop_d    = stop_q;
      rep_load  = 1'b0;
      rep_val   = '0;
      rep_dec   = 1'b0;
      gap_load  = 1'b0;
      gap_val   = '0;
      gap_dec   = 1'b0;
      case (state)
         S_IDLE: begin
            stop_d = 1'b0;
            if (start) begin
               state_d   = S_SHIFT;
               pat_d     = pat;
               sr_d      = pat;
               bit_cnt_d = '0;
               gap_d     = gap;
               rep_load  = 1'b1;
               rep_val   = (reps == '0) ? '0 : reps - 1'b1;
            end
         end
         S_SHIFT: begin
            stop_d = stop_seen;
            if (!last_bit) begin
               sr_d      = sr_q << 1;
               bit_cnt_d = bit_cnt + 1'b1;
            end else if (!rep_zero && !stop_seen) begin
               rep_dec = 1'b1;
               if (gap_q == '0) begin
                  sr_d      = pat_q;
                  bit_cnt_d = '0;
               end else begin
                  state_d  = S_GAP;
                  gap_load = 1'b1;
                  gap_val  = gap_q - 1'b1;
               end
            end else begin
               state_d = S_DONE;
            end
         end
         S_GAP: begin
            stop_d = stop_seen;
            if (stop_seen) begin
               state_d = S_DONE;
            end else if (gap_zero) begin
               state_d   = S_SHIFT;
               sr_d      = pat_q;
               bit_cnt_d = '0;
            end else begin
               gap_dec = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register alongside it
   always_comb begin
      out_d.valid = (state_d == S_SHIFT);
      out_d.x     = out_d.valid ? sr_d[PAT_W-1] : IDLE_LVL;
      out_d.frame = out_d.valid && (bit_cnt_d == '0);
      out_d.busy  = (state_d != S_IDLE);
      out_d.done  = (state_d == S_DONE);
   end

   assign x     = out_q.x;
   assign valid = out_q.valid;
   assign frame = out_q.frame;
   assign busy  = out_q.busy;
   assign done  = out_q.done;

endmodule

// File: tb/tb_moore_seq_gen.sv
// Scoreboard bench for moore_seq_gen: a timeline model queues expected outputs
// per burst, and an independent monitor pops and compares them.
module tb_moore_seq_gen;

   localparam int P = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [3:0] pat = '0;
   logic [3:0] reps = '0;
   logic [2:0] gap = '0;
   logic       x, valid, frame, busy, done;

   moore_seq_gen dut (
      .clk(clk), .rst(rst), .start(start), .pat(pat), .reps(reps),
      .gap(gap), .stop(stop), .x(x), .valid(valid), .frame(frame),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      bit x;
      bit frame;
      bit done;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Burst timeline: each repeat is P bits, decisions fall on the edge after
   // its last bit, gaps are g idle cycles, stop sampled at stop_edge.
   task automatic model(input int k, input logic [3:0] p, input int r, input int g,
                        input int stop_edge, output int done_cyc);
      int reps_eff, t, e_last;
      reps_eff = (r == 0) ? 1 : r;
      t = k;
      done_cyc = -1;
      for (int rep = 0; rep < 16; rep++) begin
         for (int b = 0; b < P; b++)
            exp_q.push_back('{cyc: t + b, x: p[P-1-b], frame: (b == 0), done: 1'b0});
         e_last = t + P;
         if (rep + 1 >= reps_eff || (stop_edge > k && stop_edge <= e_last)) begin
            done_cyc = e_last;
            break;
         end
         if (g == 0) begin
            t = e_last;
         end else if (stop_edge >= e_last + 1 && stop_edge <= e_last + g) begin
            done_cyc = stop_edge;
            break;
         end else begin
            t = e_last + g;
         end
      end
      exp_q.push_back('{cyc: done_cyc, x: 1'b0, frame: 1'b0, done: 1'b1});
   endtask

   // Monitor: consumes one expectation whenever the DUT shows a bit or done
   always @(negedge clk) begin
      if (!rst) begin
         if (valid || done) begin
            if (exp_q.size() == 0) begin
               check("spurious_output", 32'({valid, done}), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("out_cycle", 32'(cyc), 32'(mon_e.cyc));
               check("done", 32'(done), 32'(mon_e.done));
               check("valid", 32'(valid), 32'(!mon_e.done));
               check("busy_active", 32'(busy), 32'd1);
               if (!mon_e.done) begin
                  check("x", 32'(x), 32'(mon_e.x));
                  check("frame", 32'(frame), 32'(mon_e.frame));
               end
            end
         end else begin
            check("idle_x", 32'(x), 32'd0);
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
               check("missing_output", 32'(valid | done), 32'd1);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // Loopback 1011 detector on the serial line
   logic [3:0] win = '0;
   int         det_cnt = 0;
   always @(negedge clk) begin
      win = {win[2:0], x};
      if (win == 4'b1011) det_cnt++;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   // Starts a burst on the next edge; stop_off/ign_off are edge offsets from
   // the start edge for a stop pulse and an ignored start (-1: none).
   task automatic run_burst(input logic [3:0] p, input logic [3:0] r, input logic [2:0] g,
                            input int stop_off, input int ign_off);
      int k, done_cyc, stop_edge;
      k = cyc + 1;
      stop_edge = (stop_off < 0) ? -1 : k + stop_off;
      model(k, p, int'(r), int'(g), stop_edge, done_cyc);
      pat = p;
      reps = r;
      gap = g;
      start = 1'b1;
      stop = (stop_off == 0);
      for (int i = 0; i < 400; i++) begin
         step();
         if (cyc >= done_cyc + 1) break;
         start = (ign_off > 0) && (cyc + 1 == k + ign_off);
         stop  = (stop_off > 0) && (cyc + 1 == k + stop_off);
         pat   = 4'($urandom);
         reps  = 4'($urandom);
         gap   = 3'($urandom);
      end
      start = 1'b0;
      stop = 1'b0;
      check("busy_after_done", 32'(busy), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic reset_mid_burst();
      int k, dc;
      k = cyc + 1;
      model(k, 4'b1011, 5, 0, -1, dc);
      pat = 4'b1011;
      reps = 4'd5;
      gap = 3'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      idle(2);
      rst = 1'b1;
      exp_q.delete();
      step();
      check("rst_x", 32'(x), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_frame", 32'(frame), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      idle(6);
      run_burst(4'b1011, 4'd5, 3'd0, -1, -1);
   endtask

   initial begin
      int base;
      idle(3);
      check("init_x", 32'(x), 32'd0);
      check("init_valid", 32'(valid), 32'd0);
      check("init_frame", 32'(frame), 32'd0);
      check("init_busy", 32'(busy), 32'd0);
      check("init_done", 32'(done), 32'd0);
      rst = 1'b0;
      step();

      run_burst(4'b1011, 4'd1, 3'd0, -1, -1);
      run_burst(4'b1011, 4'd3, 3'd0, -1, -1);
      run_burst(4'b1011, 4'd2, 3'd2, -1, -1);
      run_burst(4'b1011, 4'd3, 3'd0, 2, 4);
      run_burst(4'b0110, 4'd2, 3'd1, 0, -1);
      run_burst(4'b1001, 4'd3, 3'd3, 6, 5);
      run_burst(4'b1110, 4'd2, 3'd0, 4, -1);
      run_burst(4'b0101, 4'd0, 3'd5, -1, 5);
      idle(4);
      base = det_cnt;
      run_burst(4'b1011, 4'd4, 3'd0, -1, -1);
      check("loopback_det", 32'(det_cnt - base), 32'd4);

      reset_mid_burst();

      for (int i = 0; i < 25; i++) begin
         int so, io;
         so = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 24)) : -1;
         io = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 24)) : -1;
         run_burst(4'($urandom), 4'($urandom_range(0, 5)), 3'($urandom_range(0, 3)), so, io);
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      end
      run_burst(4'($urandom), 4'd15, 3'd7, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
